aes_data_sel_pipe: RTL

//  Parametrised N-way selector for 128-bit AES state/key words, successor to the 3-input round-data mux.

---
 rtl/aes_sel_pkg.sv | 18 +
 rtl/aes_skid_buf.sv | 60 ++++++
 rtl/aes_data_sel_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/aes_sel_pkg.sv
// ---------------------------------------------------------------------------
// aes_sel_pkg
// Shared constants and helpers for the AES round-data selector.
//   AES_WORD_W : width of an AES state/key word
//   SEL_IDLE   : select code meaning "no channel"
//   sel_legal  : true when a select code is idle or names an existing channel
// ---------------------------------------------------------------------------
package aes_sel_pkg;

    localparam int AES_WORD_W = 128;
    localparam int unsigned SEL_IDLE = 0;

    // Codes 0..n_in are legal (0 = idle, k = channel k-1); anything above is not.
    function automatic logic sel_legal(input int unsigned sel, input int unsigned n_in);
        return (sel <= n_in);
    endfunction

endpackage

// File: rtl/aes_skid_buf.sv
// ---------------------------------------------------------------------------
// aes_skid_buf
// Two-entry valid/ready skid register. The main register M drives the output;
// the skid register S catches one word when M is stalled.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data, in_valid word being accepted this cycle (in_valid = accept strobe;
//                     the producer only asserts it while skid_full is low)
//   skid_full         S holds a word; upstream must not accept
//   out_data/out_valid/out_ready  downstream handshake (driven from M)
// ---------------------------------------------------------------------------
module aes_skid_buf #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             skid_full,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] m_data_reg;
    logic             m_valid_reg;
    logic [WIDTH-1:0] s_data_reg;
    logic             s_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_reg  <= '0;
            m_valid_reg <= 1'b0;
            s_data_reg  <= '0;
            s_valid_reg <= 1'b0;
        end else if (m_valid_reg && s_valid_reg) begin
            // Both full: upstream is blocked, so only draining S into M can happen.
            if (out_ready) begin
                m_data_reg  <= s_data_reg;
                s_valid_reg <= 1'b0;
            end
        end else if (in_valid) begin
            if (!m_valid_reg || out_ready) begin
                m_data_reg  <= in_data;
                m_valid_reg <= 1'b1;
            end else begin
                s_data_reg  <= in_data;
                s_valid_reg <= 1'b1;
            end
        end else if (out_ready) begin
            // Data register deliberately left alone so out_data holds its last word.
            m_valid_reg <= 1'b0;
        end
    end

    assign skid_full = s_valid_reg;
    assign out_data  = m_data_reg;
    assign out_valid = m_valid_reg;

endmodule

// File: rtl/aes_data_sel_pipe.sv
// ---------------------------------------------------------------------------
// aes_data_sel_pipe
// N-way selector for AES state/key words feeding the round register.
// One of N_IN valid/ready channels is chosen by an encoded select and the word
// is forwarded through a registered two-entry skid stage.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   sel         0 = idle, k = channel k-1, k > N_IN = illegal (treated as idle)
//   in_data     packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid    per-channel valid
//   in_ready    per-channel ready, one-hot or zero
//   out_data/out_valid/out_ready  downstream handshake
//   sel_err     sticky flag: illegal select seen while any input was valid
//   beat_cnt    wrapping count of accepted input beats
// ---------------------------------------------------------------------------
module aes_data_sel_pipe
    import aes_sel_pkg::*;
#(
    parameter int WIDTH = AES_WORD_W,
    parameter int N_IN  = 3,
    parameter int SEL_W = $clog2(N_IN + 1),
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    output logic [CNT_W-1:0]      beat_cnt
);

    logic             skid_full;
    logic [N_IN-1:0]  hit;
    logic [WIDTH-1:0] gated [N_IN];
    logic [WIDTH-1:0] acc_data;
    logic             accept;
    logic             sel_illegal;
    logic             sel_err_reg;
    logic [CNT_W-1:0] beat_cnt_reg;

    // Ready is a function of sel and registered state only, never of out_ready,
    // so there is no combinational path from downstream back to the sources.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
            localparam logic [SEL_W-1:0] CODE = SEL_W'(gi + 1);
            assign in_ready[gi] = (sel == CODE) & ~skid_full & ~rst;
            assign hit[gi]      = in_ready[gi] & in_valid[gi];
            assign gated[gi]    = {WIDTH{hit[gi]}} & in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // hit is at most one-hot, so OR-ing the gated words is a plain mux.
    always_comb begin
        acc_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            acc_data = acc_data | gated[i];
        end
    end

    assign accept      = |hit;
    assign sel_illegal = ~sel_legal(32'(sel), N_IN);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_reg <= 1'b0;
        end else if (sel_illegal && (|in_valid)) begin
            sel_err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_reg <= '0;
        end else if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        end
    end

    aes_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (acc_data),
        .in_valid  (accept),
        .skid_full (skid_full),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign sel_err  = sel_err_reg;
    assign beat_cnt = beat_cnt_reg;

endmodule
